// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_pkg
//  Brief    : Shared types and helpers for the sequenced MAC array:
//             FSM state encoding, accumulator saturation and ReLU clamp.
//  Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Helpers operate on a wide signed carrier so any ACC_W up to 63 fits
  localparam int SAT_W     = 64;
  localparam int DEF_ACC_W = 16;

  // Result range for the default 16-bit accumulator
  localparam logic signed [SAT_W-1:0] ACC_MAX = (64'sd1 <<< (DEF_ACC_W - 1)) - 64'sd1;
  localparam logic signed [SAT_W-1:0] ACC_MIN = -(64'sd1 <<< (DEF_ACC_W - 1));

  // Clamp a signed sum into the range of an acc_w-bit two's complement value
  function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] sum,
                                                      input int acc_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

  // max(x, 0)
  function automatic logic signed [SAT_W-1:0] relu(input logic signed [SAT_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
//  Module   : mac_lane
//  Brief    : One saturating multiply-accumulate lane. Full-precision signed
//             product is added to the accumulator with one guard bit and the
//             sum is clamped, so overflow sticks at the rail instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_lane
  import mac_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    step_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W:0]   sum;

  // Next accumulator: clear wins, a disabled lane is pinned at zero
  always_comb begin
    prod  = a_i * w_i;
    sum   = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(prod);
    acc_d = acc_q;
    if (clr_i || !en_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = ACC_W'(sat_acc(SAT_W'(sum), ACC_W));
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/mac_array_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mac_array_seq
//  Brief    : Sequences one K-deep dot-product pass over N_MACS lanes.
//             Activations stream in on a valid/ready port, results leave on
//             a valid/ready port; supports lane mask, ReLU and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_array_seq
  import mac_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int K_MAX  = 16,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [KW-1:0]             cfg_k_i,
  input  logic [N_MACS-1:0]         cfg_lane_en_i,
  input  logic                      cfg_relu_i,
  input  logic                      clear_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [W-1:0]              a_i,
  input  logic [N_MACS*W-1:0]       w_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [N_MACS*ACC_W-1:0]   out_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [KW-1:0] C_K_MAX = KW'(K_MAX);

  state_e              state_q, state_d;
  logic [KW-1:0]       cnt_q, cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic [N_MACS-1:0]   en_q, en_d;
  logic                relu_q, relu_d;
  logic                done_q, done_d;
  logic                lane_clr;
  logic                lane_step;

  // Next-state, config latching and lane control; clear overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    en_d      = en_q;
    relu_d    = relu_q;
    done_d    = 1'b0;
    lane_clr  = 1'b0;
    lane_step = 1'b0;
    if (clear_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      lane_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            k_d      = (cfg_k_i > C_K_MAX) ? C_K_MAX : cfg_k_i;
            en_d     = cfg_lane_en_i;
            relu_d   = cfg_relu_i;
            cnt_d    = '0;
            lane_clr = 1'b1;
            state_d  = (cfg_k_i == '0) ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // in_ready is high throughout ACCUM, so valid alone is a handshake
          if (in_valid_i) begin
            lane_step = 1'b1;
            cnt_d     = cnt_q + KW'(1);
            if (cnt_q + KW'(1) == k_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      en_q    <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      en_q    <= en_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
    end
  end

  // Lanes; results are shown only while draining so nothing partial leaks out
  for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
    logic signed [ACC_W-1:0] acc;

    mac_lane #(
      .W     (W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_q[gi]),
      .clr_i  (lane_clr),
      .step_i (lane_step),
      .a_i    (a_i),
      .w_i    (w_i[gi*W +: W]),
      .acc_o  (acc)
    );

    assign out_data_o[gi*ACC_W +: ACC_W] =
      (state_q == ST_DRAIN) ? (relu_q ? ACC_W'(relu(SAT_W'(acc))) : acc) : '0;
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_DRAIN);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mac_array_seq
//  Brief    : Self-checking bench for mac_array_seq: directed vector table,
//             randomized passes against a dot-product model, abort/reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_seq;
  import mac_seq_pkg::*;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [KW-1:0]     cfg_k_i = '0;
  logic [N-1:0]      cfg_lane_en_i = '0;
  logic              cfg_relu_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [W-1:0]      a_i = '0;
  logic [N*W-1:0]    w_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [N*ACC_W-1:0] out_data_o;
  logic              busy_o;
  logic              done_o;

  mac_array_seq #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .K_MAX(K_MAX), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_k_i(cfg_k_i),
    .cfg_lane_en_i(cfg_lane_en_i), .cfg_relu_i(cfg_relu_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .w_i(w_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     beat_a [K_MAX];
  int     beat_w [K_MAX][N];
  longint exp_lane [N];
  longint got_lane [N];

  typedef struct packed {
    int                      k;
    logic [3:0]              mask;
    logic                    relu;
    int                      a0;
    int                      astep;
    logic [3:0][7:0]         w;
    logic                    tog;
    int                      stall;
    logic [3:0][15:0]        expv;
    int                      exp_beats;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(int k, logic [3:0] mask, logic relu, int a0, int astep,
                              int w0, int w1, int w2, int w3, logic tog, int stall,
                              int e0, int e1, int e2, int e3, int eb);
    vec_t v;
    v.k = k; v.mask = mask; v.relu = relu; v.a0 = a0; v.astep = astep;
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    v.tog = tog; v.stall = stall;
    v.expv[0] = 16'(e0); v.expv[1] = 16'(e1); v.expv[2] = 16'(e2); v.expv[3] = 16'(e3);
    v.exp_beats = eb;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic longint lane(int l);
    logic signed [ACC_W-1:0] v;
    v = out_data_o[l*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  task automatic drive_beat(input int b);
    int idx;
    idx = (b < K_MAX) ? b : K_MAX - 1;
    a_i = 8'(beat_a[idx]);
    for (int l = 0; l < N; l++) w_i[l*W +: W] = 8'(beat_w[idx][l]);
  endtask

  // Dot product per enabled lane, clamped after every beat, then optional ReLU
  task automatic model(input int k, input logic [3:0] mask, input logic relu);
    longint acc;
    int keff;
    keff = (k > K_MAX) ? K_MAX : k;
    for (int l = 0; l < N; l++) begin
      acc = 0;
      if (mask[l]) begin
        for (int b = 0; b < keff; b++) begin
          acc = acc + longint'(beat_a[b]) * longint'(beat_w[b][l]);
          if (acc > ACC_MAX) acc = ACC_MAX;
          if (acc < ACC_MIN) acc = ACC_MIN;
        end
      end
      if (relu && acc < 0) acc = 0;
      exp_lane[l] = acc;
    end
  endtask

  // One full pass: start, stream beats, optionally stall the output, handshake
  task automatic run_pass(input int k, input logic [3:0] mask, input logic relu,
                          input logic tog, input int stall, input int exp_beats);
    int cyc;
    int beats;
    logic [N*ACC_W-1:0] snap;
    beats = 0;
    start_i = 1'b1; cfg_k_i = KW'(k); cfg_lane_en_i = mask; cfg_relu_i = relu;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    cyc = 0;
    while (!out_valid_o && cyc < 200) begin
      in_valid_i = tog ? (cyc % 2 == 0) : 1'b1;
      drive_beat(beats);
      if (in_valid_i && in_ready_o) beats++;
      @(negedge clk);
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("drain_reached", out_valid_o, 1);
    if (!tog) chk("drain_latency", cyc, exp_beats);
    chk("beats_taken", beats, exp_beats);
    chk("in_ready_in_drain", in_ready_o, 0);
    for (int l = 0; l < N; l++) got_lane[l] = lane(l);
    snap = out_data_o;
    out_ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid_o, 1);
      chk("stall_stable", longint'(out_data_o == snap), 1);
      chk("stall_no_done", done_o, 0);
      chk("stall_in_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("valid_after_hs", out_valid_o, 0);
    chk("busy_after_hs", busy_o, 0);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
  endtask

  task automatic fill_linear(input int a0, input int astep, input int w0, input int w1,
                             input int w2, input int w3);
    for (int b = 0; b < K_MAX; b++) begin
      beat_a[b] = a0 + astep * b;
      beat_w[b][0] = w0; beat_w[b][1] = w1; beat_w[b][2] = w2; beat_w[b][3] = w3;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_out_data"}, longint'(out_data_o == '0), 1);
    chk({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(3,  4'hF,    1'b0,   1, 1,  1,    2, -1,  0, 1'b0, 0,     6,     12, -6,   0,  3);
    tbl[1] = mk(3,  4'hF,    1'b0, 127, 0, 127, -128,  0,  1, 1'b0, 0, 32767, -32768,  0, 381,  3);
    tbl[2] = mk(2,  4'b0101, 1'b1,  -2, 0,  5,    5,  5,  5, 1'b0, 0,     0,      0,  0,   0,  2);
    tbl[3] = mk(2,  4'b0101, 1'b0,  -2, 0,  5,    5,  5,  5, 1'b0, 0,   -20,      0, -20,  0,  2);
    tbl[4] = mk(0,  4'hF,    1'b0,   1, 1,  1,    1,  1,  1, 1'b0, 0,     0,      0,  0,   0,  0);
    tbl[5] = mk(21, 4'hF,    1'b0,   1, 0,  1,    2,  3, -1, 1'b0, 0,    16,     32, 48, -16, 16);
    tbl[6] = mk(3,  4'hF,    1'b0,   1, 1,  1,    2, -1,  0, 1'b1, 5,     6,     12, -6,   0,  3);

    // Reset state
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      fill_linear(tbl[i].a0, tbl[i].astep, int'($signed(tbl[i].w[0])), int'($signed(tbl[i].w[1])),
                  int'($signed(tbl[i].w[2])), int'($signed(tbl[i].w[3])));
      run_pass(tbl[i].k, tbl[i].mask, tbl[i].relu, tbl[i].tog, tbl[i].stall, tbl[i].exp_beats);
      for (int l = 0; l < N; l++)
        chk($sformatf("vec%0d_lane%0d", i, l), got_lane[l], longint'($signed(tbl[i].expv[l])));
    end

    // Randomized passes against the model
    for (int r = 0; r < 20; r++) begin
      int k;
      logic [3:0] mask;
      logic relu;
      k = $urandom_range(0, 20);
      mask = 4'($urandom);
      relu = 1'($urandom);
      for (int b = 0; b < K_MAX; b++) begin
        bit extreme;
        extreme = ($urandom_range(0, 2) == 0);
        beat_a[b] = extreme ? 127 : int'($urandom_range(0, 255)) - 128;
        for (int l = 0; l < N; l++)
          beat_w[b][l] = extreme ? ((l % 2 == 0) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
      end
      model(k, mask, relu);
      run_pass(k, mask, relu, 1'($urandom), int'($urandom_range(0, 3)), (k > K_MAX) ? K_MAX : k);
      for (int l = 0; l < N; l++)
        chk($sformatf("rand%0d_lane%0d", r, l), got_lane[l], exp_lane[l]);
    end

    // Abort via clear after two beats of a four-beat pass
    fill_linear(1, 1, 1, 2, -1, 0);
    start_i = 1'b1; cfg_k_i = 5'd4; cfg_lane_en_i = 4'hF; cfg_relu_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid_i = 1'b1; drive_beat(b);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk_idle_outputs("clear_accum");
    @(negedge clk);
    chk("clear_no_done", done_o, 0);

    // clear together with start in IDLE: start is ignored
    clear_i = 1'b1; start_i = 1'b1; cfg_k_i = 5'd2;
    @(negedge clk);
    clear_i = 1'b0; start_i = 1'b0;
    chk("clear_beats_start", busy_o, 0);

    // clear while results are offered: no done pulse
    start_i = 1'b1; cfg_k_i = 5'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("k0_drain", out_valid_o, 1);
    clear_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; out_ready_i = 1'b0;
    chk("clear_drain_valid", out_valid_o, 0);
    chk("clear_drain_done", done_o, 0);

    // Async reset mid-ACCUM drops every output before the next clock edge
    start_i = 1'b1; cfg_k_i = 5'd4;
    @(negedge clk);
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid_i = 1'b1; drive_beat(b);
      @(negedge clk);
    end
    chk("accum_before_reset", in_ready_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh pass after the reset
    fill_linear(1, 1, 1, 2, -1, 0);
    run_pass(3, 4'hF, 1'b0, 1'b0, 0, 3);
    chk("post_reset_lane0", got_lane[0], 6);
    chk("post_reset_lane1", got_lane[1], 12);
    chk("post_reset_lane2", got_lane[2], -6);
    chk("post_reset_lane3", got_lane[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
Parametrised successor to the fixed 4-MAC top with hard-wired valid controllers. Sequences one K-deep dot-product pass across N_MACS lanes: takes a streamed activation with per-lane weights over a valid/ready handshake, then presents the results on a valid/ready output port. Adds a configurable depth, a lane-enable mask, saturating accumulation, optional ReLU and abort, none of which the previous generation has. Sits between the activation/weight feeders and the result writeback.

Parameters:
W, 8, signed activation/weight width
ACC_W, 16, signed accumulator/result width (ACC_W >= 2*W)
N_MACS, 4, number of MAC lanes (>=1)
K_MAX, 16, maximum dot-product depth
KW, $clog2(K_MAX+1), width of depth config/counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse, sampled in IDLE only
cfg_k  in  KW  dot-product depth, latched at start
cfg_lane_en  in  N_MACS  lane enable mask, latched at start
cfg_relu  in  1  clamp negative results to 0, latched at start
clear  in  1  synchronous abort
in_valid  in  1  activation beat valid
in_ready  out  1  block accepts a beat
a_in  in  W  signed activation, broadcast to all lanes
w_in  in  N_MACS*W  signed weights, lane i at [i*W +: W]
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
out_data  out  N_MACS*ACC_W  results, lane i at [i*ACC_W +: ACC_W]
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after result handshake

Behaviour:
- Reset (async, rst_n=0): state=IDLE; accumulators, beat counter and latched cfg = 0; in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- FSM IDLE -> ACCUM -> DRAIN -> IDLE.
- IDLE: start=1 latches cfg_k/cfg_lane_en/cfg_relu, zeros accumulators and the counter. Next state is ACCUM, or DRAIN directly when cfg_k==0 (all-zero result). cfg_k>K_MAX saturates to K_MAX. start outside IDLE is ignored.
- ACCUM: in_ready=1. A beat is accepted when in_valid&&in_ready. Each enabled lane then computes acc <= sat(acc + a_in*w_lane). Product is full 2W signed, sign-extended to ACC_W+1. Sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is sticky per beat, with no wrap. Disabled lanes hold 0.
- Counter increments per accepted beat. The cycle after the cfg_k-th accepted beat, state=DRAIN; in_ready drops in that same cycle, so no extra beat is taken.
- DRAIN: out_valid=1 and out_data = accumulators, with each lane max(acc,0) if relu is set. out_data is registered and stable while out_valid&&!out_ready. out_valid&&out_ready -> IDLE; done=1 for exactly the next cycle.
- Latency: first out_valid arrives 1 cycle after the last accepted beat. Minimum pass is cfg_k+2 cycles start-to-done, with no stalls.
- clear=1 (any state) wins over every other input that cycle: next state IDLE, accumulators 0, out_valid 0, no done pulse. clear in IDLE together with start means start is ignored.
- Back-to-back: start is accepted in the cycle done is high, because state is already IDLE.
- Async reset mid-pass aborts immediately; no partial output is presented.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, ACCUM, DRAIN); functions sat_acc(sum, ACC_W) and relu(x); ACC_MAX/ACC_MIN localparams.
- Sub-module mac_lane, instantiated N_MACS times by generate: inputs en, clr, step, a, w; output acc. It holds the saturating multiply-accumulate. The top keeps the FSM, counter, cfg latches and handshake.

Test Plan:
- Basic (W=8, ACC_W=16, N=4): cfg_k=3, mask=4'hF, a=1,2,3, lane w=(1,2,-1,0) each beat -> out_data lanes = 6, 12, -6, 0; done 1 cycle after handshake; busy low after.
- Saturation: cfg_k=3, a=127, w0=127 (sum 48387), w1=-128 -> lane0=32767, lane1=-32768, no wrap.
- Backpressure/stall: in_valid toggles 1,0,1,0,1 with cfg_k=3 -> exactly 3 beats taken. Hold out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready=0, done only after out_ready=1.
- Mask and ReLU: mask=4'b0101, cfg_relu=1, a=-2, w=5 each lane, cfg_k=2 -> lane0=0 (clamped -20), lane1=0, lane2=0, lane3=0. Same with cfg_relu=0 -> lanes 0/2 = -20, lanes 1/3 = 0.
- Edge depths: cfg_k=0 -> DRAIN next cycle with all zeros. cfg_k=K_MAX+5 -> exactly 16 beats accepted.
- Abort: clear after beat 2 of cfg_k=4 -> IDLE next cycle, no done, outputs 0. rst_n low mid-ACCUM -> all outputs 0 asynchronously. A fresh start then gives the correct result.
